ptpv2_pbus_master: RTL and testbench

PTPV2_PBUS_MASTER -- requirements
Module: ptpv2_pbus_master

---
 rtl/ptpv2_pbus_pkg.sv | 16 +
 rtl/ptpv2_pbus_master_if.sv | 43 ++++
 rtl/ptpv2_pbus_master.sv | 126 ++++++++++++
 tb/tb_ptpv2_pbus_master.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ptpv2_pbus_pkg.sv
// Shared definitions for the ptpv2 register-bus master:
// FSM encoding, timeout defaults and abort-response constants.
package ptpv2_pbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
    localparam int          CNT_W              = 16;
    localparam logic [31:0] TIMEOUT_RDATA      = 32'h0;

endpackage

// File: rtl/ptpv2_pbus_master_if.sv
// Command/response and APB-like bus bundle for the ptpv2 register master.
// master = the bridge itself, slave = its environment (requester + core).
interface ptpv2_pbus_master_if;

    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;

    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;

    logic [31:0] pbus_addr_o;
    logic        pbus_write_o;
    logic        pbus_sel_o;
    logic        pbus_enable_o;
    logic [31:0] pbus_wdata_o;
    logic [31:0] pbus_rdata_i;
    logic        pbus_ready_i;
    logic        pbus_slverr_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  pbus_rdata_i, pbus_ready_i, pbus_slverr_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output pbus_addr_o, pbus_write_o, pbus_sel_o,
        output pbus_enable_o, pbus_wdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output pbus_rdata_i, pbus_ready_i, pbus_slverr_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  pbus_addr_o, pbus_write_o, pbus_sel_o,
        input  pbus_enable_o, pbus_wdata_o
    );

endinterface

// File: rtl/ptpv2_pbus_master.sv
// Single-outstanding APB-like master for the ptpv2 core register slave.
// Define PBUS_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES without ready.
module ptpv2_pbus_master
    import ptpv2_pbus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 pbus_clk,
    input  logic                 pbus_rst,
    ptpv2_pbus_master_if.master  bus
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_done;
    logic        w_expire;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_write;
    logic [31:0] r_rdata;
    logic        r_err;

    assign w_accept = (r_state == ST_IDLE) & bus.cmd_valid_i;
    assign w_done   = (r_state == ST_ACCESS) & bus.pbus_ready_i;

`ifdef PBUS_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_to;

    assign w_cnt_inc = r_cnt + 1'b1;
    // ready on the limit cycle wins, so expiry requires ready low
    assign w_expire  = (r_state == ST_ACCESS) & ~bus.pbus_ready_i &
                       (w_cnt_inc == TIMEOUT_CYCLES[CNT_W-1:0]);

    always_ff @(posedge pbus_clk or posedge pbus_rst) begin
        if (pbus_rst) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
        end else begin
            if (r_state != ST_ACCESS) r_cnt <= '0;
            else if (!bus.pbus_ready_i) r_cnt <= w_cnt_inc;
            if (w_done) r_to <= 1'b0;
            else if (w_expire) r_to <= 1'b1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge pbus_clk or posedge pbus_rst) begin
        if (pbus_rst) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (bus.cmd_valid_i) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (w_done | w_expire) w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pbus_clk or posedge pbus_rst) begin
        if (pbus_rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.cmd_addr_i;
                r_wdata <= bus.cmd_wdata_i;
                r_write <= bus.cmd_write_i;
            end
            if (w_done) begin
                r_err   <= bus.pbus_slverr_i;
                r_rdata <= (r_write | bus.pbus_slverr_i) ? 32'h0
                                                         : bus.pbus_rdata_i;
            end else if (w_expire) begin
                r_err   <= 1'b1;
                r_rdata <= TIMEOUT_RDATA;
            end
        end
    end

    // strobes decode straight from state so reset drops them at once
    always_comb begin
        bus.cmd_ready_o   = (r_state == ST_IDLE) & ~pbus_rst;
        bus.pbus_sel_o    = 1'b0;
        bus.pbus_enable_o = 1'b0;
        bus.rsp_valid_o   = 1'b0;
        bus.rsp_rdata_o   = 32'h0;
        bus.rsp_err_o     = 1'b0;
        bus.rsp_timeout_o = 1'b0;
        unique case (1'b1)
            (r_state == ST_SETUP): begin
                bus.pbus_sel_o = 1'b1;
            end
            (r_state == ST_ACCESS): begin
                bus.pbus_sel_o    = 1'b1;
                bus.pbus_enable_o = 1'b1;
            end
            (r_state == ST_RESP): begin
                bus.rsp_valid_o = 1'b1;
                bus.rsp_rdata_o = r_rdata;
                bus.rsp_err_o   = r_err;
`ifdef PBUS_TIMEOUT_EN
                bus.rsp_timeout_o = r_to;
`endif
            end
            default: ;
        endcase
    end

    assign bus.pbus_addr_o  = r_addr;
    assign bus.pbus_wdata_o = r_wdata;
    assign bus.pbus_write_o = r_write;

endmodule

// File: tb/tb_ptpv2_pbus_master.sv
// Directed bench for ptpv2_pbus_master: latency, wait states, slverr,
// reset abort, back-to-back commands and (with PBUS_TIMEOUT_EN) timeout.
module tb_ptpv2_pbus_master;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ptpv2_pbus_master_if bus ();

    ptpv2_pbus_master #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pbus_clk (clk),
        .pbus_rst (rst),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic bus_quiet();
        bus.cmd_valid_i   = 1'b0;
        bus.cmd_write_i   = 1'b0;
        bus.cmd_addr_i    = 32'h0;
        bus.cmd_wdata_i   = 32'h0;
        bus.pbus_ready_i  = 1'b0;
        bus.pbus_slverr_i = 1'b0;
        bus.pbus_rdata_i  = 32'h0;
    endtask

    // waits < 0 : slave never answers
    task automatic xfer(input string tag, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd,
                        input logic se, input int exp_k,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input logic exp_to);
        int k = 0;
        int acc = 0;
        int n_setup = 0;
        int n_stable = 0;
        bit seen = 0;
        @(negedge clk);
        chk({tag, ".cmd_ready"}, 32'(bus.cmd_ready_o), 32'd1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = wr;
        bus.cmd_addr_i  = a;
        bus.cmd_wdata_i = wd;
        @(posedge clk);
        #1 bus.cmd_valid_i = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            bus.pbus_ready_i  = 1'b0;
            bus.pbus_slverr_i = 1'b0;
            bus.pbus_rdata_i  = 32'hDEAD_BEEF;
            if (bus.rsp_valid_o) begin
                seen = 1;
                chk({tag, ".rdata"}, bus.rsp_rdata_o, exp_rd);
                chk({tag, ".err"}, 32'(bus.rsp_err_o), 32'(exp_err));
                chk({tag, ".timeout"}, 32'(bus.rsp_timeout_o),
                    32'(exp_to));
            end else begin
                if (bus.pbus_sel_o && bus.pbus_addr_o == a &&
                    bus.pbus_write_o == wr && bus.pbus_wdata_o == wd)
                    n_stable++;
                if (bus.pbus_sel_o && !bus.pbus_enable_o) begin
                    n_setup++;
                    bus.pbus_ready_i  = 1'b1;
                    bus.pbus_slverr_i = 1'b1;
                end else if (bus.pbus_sel_o && bus.pbus_enable_o) begin
                    if (waits >= 0 && acc == waits) begin
                        bus.pbus_ready_i  = 1'b1;
                        bus.pbus_slverr_i = se;
                        bus.pbus_rdata_i  = rd;
                    end
                    acc++;
                end
            end
        end
        chk({tag, ".rsp_seen"}, 32'(seen), 32'd1);
        chk({tag, ".latency"}, k, exp_k);
        chk({tag, ".setup_cycles"}, n_setup, 32'd1);
        chk({tag, ".addr_stable"}, n_stable, exp_k - 1);
        @(negedge clk);
        chk({tag, ".rsp_drop"},
            {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o},
            32'd0);
        chk({tag, ".rdata_idle"}, bus.rsp_rdata_o, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_c [$];
        int n_rsp;
        bus_quiet();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
        chk("rst.strobes", {bus.pbus_sel_o, bus.pbus_enable_o,
                            bus.pbus_write_o, bus.rsp_valid_o}, 32'd0);
        chk("rst.addr", bus.pbus_addr_o, 32'h0);
        chk("rst.wdata", bus.pbus_wdata_o, 32'h0);
        chk("rst.rsp", {bus.rsp_err_o, bus.rsp_timeout_o}, 32'd0);
        chk("rst.rdata", bus.rsp_rdata_o, 32'h0);
        rst = 1'b0;
        #1 chk("rel.cmd_ready", 32'(bus.cmd_ready_o), 32'd1);

        xfer("rd0", 1'b0, 32'h10, 32'h0, 0, 32'h1234_5678, 1'b0,
             3, 32'h1234_5678, 1'b0, 1'b0);
        xfer("wr3", 1'b1, 32'h20, 32'hA5A5_A5A5, 3, 32'hFFFF_0000, 1'b0,
             6, 32'h0, 1'b0, 1'b0);
        chk("wr3.addr_hold", bus.pbus_addr_o, 32'h20);
        xfer("rderr", 1'b0, 32'h30, 32'h0, 1, 32'h5555_AAAA, 1'b1,
             4, 32'h0, 1'b1, 1'b0);
        xfer("rd2", 1'b0, 32'h34, 32'h0, 2, 32'hCAFE_0001, 1'b0,
             5, 32'hCAFE_0001, 1'b0, 1'b0);
`ifdef PBUS_TIMEOUT_EN
        xfer("tmo", 1'b0, 32'h44, 32'h0, -1, 32'h0, 1'b0,
             6, 32'h0, 1'b1, 1'b1);
        xfer("tmo_rdy", 1'b0, 32'h48, 32'h0, 3, 32'h0BAD_F00D, 1'b0,
             6, 32'h0BAD_F00D, 1'b0, 1'b0);
`endif

        // reset during ACCESS
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 32'h40;
        @(posedge clk);
        #1 bus.cmd_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstx.in_access", 32'(bus.pbus_enable_o), 32'd1);
        #2 rst = 1'b1;
        #1 chk("rstx.strobes", {bus.pbus_sel_o, bus.pbus_enable_o,
                                bus.cmd_ready_o, bus.rsp_valid_o}, 32'd0);
        bus.pbus_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rstx.no_rsp", 32'(bus.rsp_valid_o), 32'd0);
        bus.pbus_ready_i = 1'b0;
        rst = 1'b0;
        #1 chk("rstx.ready_back", 32'(bus.cmd_ready_o), 32'd1);
        @(negedge clk);
        chk("rstx.no_rsp2", 32'(bus.rsp_valid_o), 32'd0);
        xfer("post_rst", 1'b0, 32'h50, 32'h0, 0, 32'h0000_00C3, 1'b0,
             3, 32'h0000_00C3, 1'b0, 1'b0);

        // cmd_valid held high, zero-wait slave
        @(negedge clk);
        bus.cmd_valid_i  = 1'b1;
        bus.cmd_addr_i   = 32'h100;
        bus.pbus_ready_i = 1'b1;
        n_rsp = 0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.rsp_valid_o) n_rsp++;
            if (bus.cmd_ready_o) begin
                acc_c.push_back(c);
                chk("b2b.idle_only", {bus.pbus_sel_o, bus.rsp_valid_o},
                    32'd0);
            end
        end
        bus_quiet();
        chk("b2b.accepts", acc_c.size(), 32'd4);
        chk("b2b.rsps", n_rsp, 32'd4);
        for (int i = 1; i < acc_c.size(); i++)
            chk("b2b.spacing", acc_c[i] - acc_c[i-1], 32'd4);
        repeat (4) @(negedge clk);
        chk("end.idle", 32'(bus.cmd_ready_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
